imem_arbiter: RTL and testbench

Shares the single combinational read port of the instruction memory between the fetch stage and a second requester: the data-side load path for reads of the text section and debug reads. It does one memory read per cycle and registers the read data, so every response arrives exactly one cycle after its grant. Arbitration is round-robin when both ports contend. Fetch responses can be cancelled on a pipeline flush, and fetch stall cycles are counted for performance debug.

---
 rtl/imem_arbiter_pkg.sv | 13 +
 rtl/imem_rr_arb.sv | 36 +++
 rtl/imem_arbiter.sv | 95 +++++++++
 tb/tb_imem_arbiter.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_arbiter_pkg.sv
// Shared definitions for the instruction-memory read-port arbiter.
// The memory macro uses IMEM_IDX_W too, so both agree on depth.
package imem_arbiter_pkg;

    localparam int IMEM_IDX_W = 12;

    typedef enum logic [1:0] {
        OWN_NONE  = 2'd0,
        OWN_FETCH = 2'd1,
        OWN_DATA  = 2'd2
    } owner_t;

endpackage

// File: rtl/imem_rr_arb.sv
// Two-way round-robin grant between fetch and data requesters.
// The last-grant register only moves on contended cycles.
module imem_rr_arb (
    input  logic clk_i,
    input  logic rst_i,
    input  logic req_f_i,
    input  logic req_d_i,
    input  logic upd_i,
    output logic gnt_f_o,
    output logic gnt_d_o
);

    // 1: data won the last contention, so fetch wins the next one
    logic last_d;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            last_d <= 1'b1;
        end else if (upd_i) begin
            last_d <= gnt_d_o;
        end
    end

    always_comb begin
        gnt_f_o = 1'b0;
        gnt_d_o = 1'b0;
        if (req_f_i && req_d_i) begin
            gnt_f_o = last_d;
            gnt_d_o = !last_d;
        end else begin
            gnt_f_o = req_f_i;
            gnt_d_o = req_d_i;
        end
    end

endmodule

// File: rtl/imem_arbiter.sv
// Shares the instruction memory read port between fetch and data/debug.
// One read per cycle; read data is registered, so responses follow grants by one cycle.
module imem_arbiter
    import imem_arbiter_pkg::*;
#(
    parameter int IDX_W = IMEM_IDX_W,
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             f_req_valid_i,
    input  logic [31:0]      f_req_addr_i,
    output logic             f_req_ready_o,
    output logic             f_rsp_valid_o,
    output logic [31:0]      f_rsp_rdata_o,
    input  logic             flush_i,
    input  logic             d_req_valid_i,
    input  logic [31:0]      d_req_addr_i,
    output logic             d_req_ready_o,
    output logic             d_rsp_valid_o,
    output logic [31:0]      d_rsp_rdata_o,
    output logic             d_rsp_err_o,
    output logic [31:0]      mem_addr_o,
    input  logic [31:0]      mem_rdata_i,
    output logic [CNT_W-1:0] f_stall_cnt_o
);

    logic             f_req;
    logic             gnt_f;
    logic             gnt_d;
    logic             d_err;
    logic             stall;
    owner_t           rsp_own_q;
    logic [31:0]      rsp_rdata_q;
    logic             rsp_err_q;
    logic [CNT_W-1:0] stall_cnt_q;

    // A flush blocks fetch from arbitrating at all
    assign f_req = f_req_valid_i && !flush_i;

    imem_rr_arb u_arb (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .req_f_i (f_req),
        .req_d_i (d_req_valid_i),
        .upd_i   (f_req && d_req_valid_i),
        .gnt_f_o (gnt_f),
        .gnt_d_o (gnt_d)
    );

    assign d_err = (d_req_addr_i[1:0] != 2'b00)
                || ((d_req_addr_i >> (IDX_W + 2)) != 32'd0);

    assign f_req_ready_o = gnt_f;
    assign d_req_ready_o = gnt_d;
    assign mem_addr_o    = (gnt_d && !d_err) ? d_req_addr_i : f_req_addr_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rsp_own_q   <= OWN_NONE;
            rsp_rdata_q <= 32'd0;
            rsp_err_q   <= 1'b0;
        end else begin
            rsp_err_q <= gnt_d && d_err;
            if (gnt_f) begin
                rsp_own_q   <= OWN_FETCH;
                rsp_rdata_q <= mem_rdata_i;
            end else if (gnt_d) begin
                rsp_own_q   <= OWN_DATA;
                rsp_rdata_q <= d_err ? 32'd0 : mem_rdata_i;
            end else begin
                rsp_own_q <= OWN_NONE;
            end
        end
    end

    assign f_rsp_valid_o = (rsp_own_q == OWN_FETCH) && !flush_i;
    assign f_rsp_rdata_o = rsp_rdata_q;
    assign d_rsp_valid_o = (rsp_own_q == OWN_DATA);
    assign d_rsp_rdata_o = rsp_rdata_q;
    assign d_rsp_err_o   = rsp_err_q;

    assign stall = f_req_valid_i && !gnt_f && !flush_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stall_cnt_q <= '0;
        end else if (stall && !(&stall_cnt_q)) begin
            stall_cnt_q <= stall_cnt_q + 1'b1;
        end
    end

    assign f_stall_cnt_o = stall_cnt_q;

endmodule

// File: tb/tb_imem_arbiter.sv
// Scoreboard bench for imem_arbiter: a cycle-level reference model predicts
// grants and responses; a monitor checks each presented response.
module tb_imem_arbiter;
    import imem_arbiter_pkg::*;

    localparam int IDX_W = IMEM_IDX_W;
    localparam int CNT_W = 16;
    localparam int DEPTH = 1 << IDX_W;

    logic             clk_i;
    logic             rst_i;
    logic             f_req_valid_i;
    logic [31:0]      f_req_addr_i;
    logic             f_req_ready_o;
    logic             f_rsp_valid_o;
    logic [31:0]      f_rsp_rdata_o;
    logic             flush_i;
    logic             d_req_valid_i;
    logic [31:0]      d_req_addr_i;
    logic             d_req_ready_o;
    logic             d_rsp_valid_o;
    logic [31:0]      d_rsp_rdata_o;
    logic             d_rsp_err_o;
    logic [31:0]      mem_addr_o;
    logic [31:0]      mem_rdata_i;
    logic [CNT_W-1:0] f_stall_cnt_o;

    logic [31:0] mem [0:DEPTH-1];

    imem_arbiter #(.IDX_W(IDX_W), .CNT_W(CNT_W)) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .f_req_valid_i (f_req_valid_i),
        .f_req_addr_i  (f_req_addr_i),
        .f_req_ready_o (f_req_ready_o),
        .f_rsp_valid_o (f_rsp_valid_o),
        .f_rsp_rdata_o (f_rsp_rdata_o),
        .flush_i       (flush_i),
        .d_req_valid_i (d_req_valid_i),
        .d_req_addr_i  (d_req_addr_i),
        .d_req_ready_o (d_req_ready_o),
        .d_rsp_valid_o (d_rsp_valid_o),
        .d_rsp_rdata_o (d_rsp_rdata_o),
        .d_rsp_err_o   (d_rsp_err_o),
        .mem_addr_o    (mem_addr_o),
        .mem_rdata_i   (mem_rdata_i),
        .f_stall_cnt_o (f_stall_cnt_o)
    );

    assign mem_rdata_i = mem[mem_addr_o[IDX_W+1:2]];

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    typedef struct {
        int          due;
        logic [31:0] data;
        logic        err;
    } rsp_t;

    rsp_t        fq[$];
    rsp_t        dq[$];
    int          n_chk;
    int          n_fail;
    int          cyc;
    bit          m_fetch_won;
    bit          m_force;
    bit          scramble;
    int unsigned m_cnt;
    int          last_idx;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        rst_i = 1'b1;
        f_req_valid_i = 1'b1;
        d_req_valid_i = 1'b0;
        flush_i = 1'b0;
        fq.delete();
        dq.delete();
        m_fetch_won = 1'b0;
        m_cnt = 0;
        #1;
        chk("rst_f_ready", f_req_ready_o, 1);
        chk("rst_d_ready", d_req_ready_o, 0);
        chk("rst_f_valid", f_rsp_valid_o, 0);
        chk("rst_d_valid", d_rsp_valid_o, 0);
        chk("rst_f_rdata", f_rsp_rdata_o, 0);
        chk("rst_d_rdata", d_rsp_rdata_o, 0);
        chk("rst_d_err", d_rsp_err_o, 0);
        chk("rst_stall_cnt", f_stall_cnt_o, 0);
        @(negedge clk_i);
        rst_i = 1'b0;
        f_req_valid_i = 1'b0;
    endtask

    // One model cycle: decide grants from the rules, predict responses
    task automatic drive(bit fv, logic [31:0] fa, bit dv, logic [31:0] da, bit fl);
        bit          fe;
        bit          gf;
        bit          gd;
        bit          derr;
        logic [31:0] ea;
        @(negedge clk_i);
        if (scramble && $urandom_range(1, 0) == 1)
            mem[last_idx] = $urandom;
        cyc++;
        f_req_valid_i = fv;
        f_req_addr_i  = fa;
        d_req_valid_i = dv;
        d_req_addr_i  = da;
        flush_i       = fl;
        if (fl && fq.size() > 0 && fq[0].due == cyc)
            void'(fq.pop_front());
        fe   = fv && !fl;
        derr = (da % 4 != 0) || (da >= (32'd4 << IDX_W));
        if (fe && dv) begin
            if (m_force) begin
                gf = 1'b0;
                gd = 1'b1;
            end else begin
                gf = !m_fetch_won;
                gd = m_fetch_won;
                m_fetch_won = gf;
            end
        end else begin
            gf = fe;
            gd = dv;
        end
        ea = (gd && !derr) ? da : fa;
        #1;
        chk("f_ready", f_req_ready_o, gf);
        chk("d_ready", d_req_ready_o, gd);
        chk("mem_addr", mem_addr_o, ea);
        chk("stall_cnt", f_stall_cnt_o, m_cnt);
        if (gf) begin
            last_idx = int'((fa / 4) % DEPTH);
            fq.push_back('{due: cyc + 1, data: mem[last_idx], err: 1'b0});
        end
        if (gd) begin
            if (!derr) last_idx = int'(da / 4);
            dq.push_back('{due: cyc + 1,
                           data: derr ? 32'd0 : mem[int'(da / 4) % DEPTH],
                           err: derr});
        end
        if (fv && !gf && !fl && m_cnt < 32'hFFFF)
            m_cnt++;
    endtask

    initial begin : monitor
        rsp_t r;
        bit   due;
        forever begin
            @(negedge clk_i);
            #2;
            due = fq.size() > 0 && fq[0].due == cyc;
            chk("f_rsp_valid", f_rsp_valid_o, due);
            if (due) begin
                r = fq.pop_front();
                if (f_rsp_valid_o) chk("f_rsp_rdata", f_rsp_rdata_o, r.data);
            end
            due = dq.size() > 0 && dq[0].due == cyc;
            chk("d_rsp_valid", d_rsp_valid_o, due);
            if (due) begin
                r = dq.pop_front();
                if (d_rsp_valid_o) begin
                    chk("d_rsp_rdata", d_rsp_rdata_o, r.data);
                    chk("d_rsp_err", d_rsp_err_o, r.err);
                end
            end
        end
    end

    initial begin
        logic [31:0] a;
        n_chk = 0;
        n_fail = 0;
        cyc = 0;
        m_force = 1'b0;
        scramble = 1'b0;
        last_idx = 0;
        m_fetch_won = 1'b0;
        m_cnt = 0;
        for (int i = 0; i < DEPTH; i++) mem[i] = $urandom;
        rst_i = 1'b0;
        f_req_valid_i = 1'b0;
        f_req_addr_i = 32'd0;
        d_req_valid_i = 1'b0;
        d_req_addr_i = 32'd0;
        flush_i = 1'b0;
        do_reset();

        mem[0] = 32'hAAAA_0001;
        mem[1] = 32'hBBBB_0002;
        mem[2] = 32'hCCCC_0003;
        drive(1, 32'h0, 0, 32'h0, 0);
        drive(1, 32'h4, 0, 32'h0, 0);
        drive(1, 32'h8, 0, 32'h0, 0);
        drive(0, 32'h0, 0, 32'h0, 0);

        do_reset();
        for (int i = 0; i < 4; i++)
            drive(1, 32'h10 + 32'(4 * i), 1, 32'h200 + 32'(4 * i), 0);
        drive(0, 32'h0, 0, 32'h0, 0);
        chk("rr_stall_cnt", f_stall_cnt_o, 2);

        drive(0, 32'h0, 1, 32'h102, 0);
        drive(0, 32'h0, 1, 32'h4000, 0);
        drive(0, 32'h0, 0, 32'h0, 0);

        drive(1, 32'h40, 0, 32'h0, 0);
        drive(1, 32'h44, 1, 32'h80, 1);
        drive(0, 32'h0, 0, 32'h0, 0);

        drive(1, 32'h48, 0, 32'h0, 0);
        do_reset();
        drive(0, 32'h0, 0, 32'h0, 0);

        scramble = 1'b1;
        for (int i = 0; i < 500; i++) begin
            case ($urandom_range(3, 0))
                0: a = 32'(4 * $urandom_range(DEPTH - 1, 0)) | 32'($urandom_range(3, 1));
                1: a = $urandom | 32'h0001_0000;
                default: a = 32'(4 * $urandom_range(DEPTH - 1, 0));
            endcase
            drive($urandom_range(3, 0) != 0, 32'(4 * $urandom_range(DEPTH - 1, 0)),
                  $urandom_range(1, 0) == 1, a, $urandom_range(6, 0) == 0);
        end
        scramble = 1'b0;
        drive(0, 32'h0, 0, 32'h0, 0);

        do_reset();
        m_force = 1'b1;
        force dut.u_arb.last_d = 1'b0;
        for (int i = 0; i < 70000; i++)
            drive(1, 32'h0, 1, 32'h3, 0);
        release dut.u_arb.last_d;
        m_force = 1'b0;
        drive(0, 32'h0, 0, 32'h0, 0);
        chk("stall_sat", f_stall_cnt_o, 32'hFFFF);
        drive(0, 32'h0, 0, 32'h0, 0);
        drive(0, 32'h0, 0, 32'h0, 0);
        chk("fq_drained", fq.size(), 0);
        chk("dq_drained", dq.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
